// File: rtl/e_stage_feed.sv
// Execute-stage feed: D/E pipeline register with bubble/hold control and
// M/W-stage operand forwarding into the ALU inputs.
module e_stage_feed (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  aluop_D,
  input  logic [4:0]  shamt_D,
  input  logic        alusrc_D,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [31:0] rs_data_D,
  input  logic [31:0] rt_data_D,
  input  logic [31:0] imm_D,
  input  logic [4:0]  wreg_D,
  input  logic [4:0]  m_wreg,
  input  logic [31:0] m_wdata,
  input  logic [4:0]  w_wreg,
  input  logic [31:0] w_wdata,
  output logic [31:0] data1_E,
  output logic [31:0] data2_E,
  output logic [3:0]  aluop,
  output logic [4:0]  s_alu,
  output logic [31:0] rt_fwd_E,
  output logic [4:0]  rs_E,
  output logic [4:0]  rt_E,
  output logic [4:0]  wreg_E,
  output logic        valid_E
);

  logic        alusrc_E;
  logic [31:0] rs_data_E;
  logic [31:0] rt_data_E;
  logic [31:0] imm_E;
  logic [31:0] rs_fwd;

  // A bubble is the all-zero bundle: aluop 0 is add, so the ALU yields 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluop     <= 4'd0;
      s_alu     <= 5'd0;
      alusrc_E  <= 1'b0;
      rs_E      <= 5'd0;
      rt_E      <= 5'd0;
      rs_data_E <= 32'd0;
      rt_data_E <= 32'd0;
      imm_E     <= 32'd0;
      wreg_E    <= 5'd0;
      valid_E   <= 1'b0;
    end else if (clr) begin
      aluop     <= 4'd0;
      s_alu     <= 5'd0;
      alusrc_E  <= 1'b0;
      rs_E      <= 5'd0;
      rt_E      <= 5'd0;
      rs_data_E <= 32'd0;
      rt_data_E <= 32'd0;
      imm_E     <= 32'd0;
      wreg_E    <= 5'd0;
      valid_E   <= 1'b0;
    end else if (en) begin
      aluop     <= aluop_D;
      s_alu     <= shamt_D;
      alusrc_E  <= alusrc_D;
      rs_E      <= rs_D;
      rt_E      <= rt_D;
      rs_data_E <= rs_data_D;
      rt_data_E <= rt_data_D;
      imm_E     <= imm_D;
      wreg_E    <= wreg_D;
      valid_E   <= 1'b1;
    end
  end

  // Register 0 is never forwarded; M is newer than W so it wins.
  function automatic logic [31:0] fwd_sel(input logic [4:0]  r,
                                          input logic [31:0] d,
                                          input logic [4:0]  mr,
                                          input logic [31:0] md,
                                          input logic [4:0]  wr,
                                          input logic [31:0] wd);
    if (r == 5'd0)     return d;
    else if (r == mr)  return md;
    else if (r == wr)  return wd;
    else               return d;
  endfunction

  always_comb begin
    rs_fwd   = fwd_sel(rs_E, rs_data_E, m_wreg, m_wdata, w_wreg, w_wdata);
    rt_fwd_E = fwd_sel(rt_E, rt_data_E, m_wreg, m_wdata, w_wreg, w_wdata);
    data1_E  = rs_fwd;
    data2_E  = alusrc_E ? imm_E : rt_fwd_E;
  end

endmodule

// File: doc/e_stage_feed.md
# e_stage_feed

Execute-stage feed for the five-stage MIPS pipeline. It latches the decode-stage operation bundle into the D/E pipeline register, applies bubble insertion and hold, and resolves M- and W-stage forwarding. It then drives the ALU operand, opcode and shift-amount inputs (`data1_E`, `data2_E`, `aluop`, `s_alu`). It is the producing end of the ALU's input interface and carries the E-stage destination information that the hazard unit needs.

## Interface
- No parameters.
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears the D/E register to a bubble.
- `clr` input 1: insert a bubble into E at the next edge.
- `en` input 1: load the D-stage bundle; when low (and `clr` low), E holds.
- `aluop_D` input 4: ALU opcode from the decoder (same encoding the ALU consumes).
- `shamt_D` input 5: instruction shamt field.
- `alusrc_D` input 1: 1 selects `imm_D` as operand 2, 0 selects the rt value.
- `rs_D`, `rt_D` input 5 each: source register numbers.
- `rs_data_D`, `rt_data_D` input 32 each: register-file read data (already W-bypassed inside the RF).
- `imm_D` input 32: extended immediate.
- `wreg_D` input 5: destination register (0 = no write).
- `m_wreg`, `m_wdata` input 5/32: M-stage destination and ALU result available for forwarding.
- `w_wreg`, `w_wdata` input 5/32: W-stage destination and write-back data.
- `data1_E` output 32: ALU operand 1 (forwarded rs).
- `data2_E` output 32: ALU operand 2 (`imm` or forwarded rt).
- `aluop` output 4: registered opcode.
- `s_alu` output 5: registered shift amount.
- `rt_fwd_E` output 32: forwarded rt value, for store data.
- `rs_E`, `rt_E`, `wreg_E` output 5 each: registered register numbers, for the hazard unit.
- `valid_E` output 1: 1 = real instruction, 0 = bubble.

## Operation
- The D/E register holds `aluop`, `shamt`, `alusrc`, `rs`, `rt`, `rs_data`, `rt_data`, `imm`, `wreg` and `valid`.
- Priority at each rising edge:
  - `reset` (asynchronous) first.
  - Then `clr`: bubble.
  - Then `en`: load D fields with `valid` = 1.
  - Otherwise hold.
- Bubble contents: all fields 0, `aluop` = 0000 (add), `valid` = 0. A bubble therefore produces ALU result 0 and `wreg_E` = 0.
- Forwarding is combinational from the registered fields, evaluated per source (rs and rt independently):
  - If the register number is 0, use the registered data unmodified.
  - Else if it equals `m_wreg`, use `m_wdata`.
  - Else if it equals `w_wreg`, use `w_wdata`.
  - Else use the registered data.
  - M has priority over W when both match.
- Output drive:
  - `data1_E` = forwarded rs.
  - `rt_fwd_E` = forwarded rt.
  - `data2_E` = `imm` when `alusrc` = 1, else forwarded rt. Forwarding never overrides `imm`.
  - `s_alu` = registered `shamt`. Variable shifts (`sllv`/`srlv`) take the amount from `data1_E[4:0]` inside the ALU, not from this block.
- Forwarding applies identically to bubbles. This is harmless because bubble register numbers are 0.

## Timing
- Reset values: `aluop` = 0, `s_alu` = 0, `rs_E` = `rt_E` = `wreg_E` = 0, `valid_E` = 0. `data1_E`, `data2_E` and `rt_fwd_E` = 0 unless a forwarding source matches register 0, which is impossible by the rule above. Reset takes effect immediately, with no clock required.
- Latency: D-stage inputs present before edge N appear on the registered outputs after edge N (one cycle).
- Forwarded outputs follow `m_*`/`w_*` changes within the same cycle, combinationally with no added latency.
- `clr` and `en` high together: bubble wins. This is the load-use stall case, where D holds and E receives a bubble.
- `en` low with `clr` low: every registered output is stable across edges. Forwarded outputs may still change when `m_*`/`w_*` change.
- Reset asserted mid-stall: bubble immediately. After deassertion, the first edge with `en` = 1 loads normally.
- No internal counters; the only state is the D/E register.

## Test plan
- Reset then idle: assert `reset` asynchronously mid-cycle -> `valid_E` = 0, `aluop` = 0, `data1_E` = `data2_E` = 0 before the next edge.
- Plain load: `aluop_D` = 0001, `rs_data_D` = 10, `rt_data_D` = 3, `alusrc_D` = 0, `en` = 1 -> after one edge `data1_E` = 10, `data2_E` = 3, `aluop` = 0001, `valid_E` = 1.
- Forward priority:
  - E rs = 5, `m_wreg` = 5 with `m_wdata` = 0xAAAA, `w_wreg` = 5 with `w_wdata` = 0xBBBB -> `data1_E` = 0xAAAA.
  - Drop `m_wreg` to 0 -> `data1_E` = 0xBBBB in the same cycle.
- Register 0 guard: rs = 0, `m_wreg` = 0, `m_wdata` = 0xFFFF -> `data1_E` = registered `rs_data` (0).
- Immediate vs forward: `alusrc` = 1, `imm` = 0x1234, rt = 7, `m_wreg` = 7 -> `data2_E` = 0x1234 and `rt_fwd_E` = `m_wdata`.
- Stall/flush:
  - `clr` = `en` = 1 -> bubble (`valid_E` = 0, `wreg_E` = 0).
  - `en` = 0 for 3 edges -> `aluop`, `s_alu` (e.g. 0x1F with `aluop` 1110) and register numbers unchanged.
